// File: rtl/sdram_mem_tester.sv
// Built-in write/read-back self test that drives the SDRAM controller's single-beat AXI-style port.
// Build option SDRAM_MEM_TESTER_LFSR_EN selects a 16-bit LFSR pattern; the default pattern is address XOR 0xAAAA.
module sdram_mem_tester #(
   parameter int ADDR_WIDTH     = 25,
   parameter int DATA_WIDTH     = 16,
   parameter int START_ADDR     = 0,
   parameter int WORD_COUNT     = 1024,
   parameter int ERR_CNT_WIDTH  = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_CNT_WIDTH-1:0] error_count,
   output logic [ADDR_WIDTH-1:0]    first_error_addr,
   output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [DATA_WIDTH-1:0]    m_axi_wdata,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready
);

   localparam int CNT_WIDTH = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam int TMO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [ADDR_WIDTH-1:0] START_WORD = ADDR_WIDTH'(START_ADDR);

   typedef enum logic [2:0] {IDLE, WRITE, READ_REQ, READ_WAIT, DONE} state_t;

   state_t                   state;
   logic [ADDR_WIDTH-1:0]    addr;
   logic [ADDR_WIDTH-1:0]    addr_next;
   logic [DATA_WIDTH-1:0]    pattern;
   logic [DATA_WIDTH-1:0]    seed_pattern;
   logic [DATA_WIDTH-1:0]    step_pattern;
   logic [CNT_WIDTH-1:0]     word_cnt;
   logic [TMO_WIDTH-1:0]     wait_cnt;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_inc;
   logic                     last_word;
   logic                     read_event;
   logic                     read_error;

   // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
   assign addr_next   = addr + 1'b1;
   assign last_word   = (word_cnt == CNT_WIDTH'(WORD_COUNT - 1));
   assign read_event  = m_axi_rvalid || (wait_cnt == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
   assign read_error  = !m_axi_rvalid || (m_axi_rdata != pattern);
   assign err_cnt_inc = (error_count == '1) ? error_count : error_count + 1'b1;

`ifdef SDRAM_MEM_TESTER_LFSR_EN
   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right with feedback into the MSB.
   assign seed_pattern = DATA_WIDTH'(16'hACE1);
   assign step_pattern = {pattern[0] ^ pattern[2] ^ pattern[3] ^ pattern[5], pattern[DATA_WIDTH-1:1]};
`else
   localparam logic [DATA_WIDTH-1:0] ALT_BITS = {DATA_WIDTH/2{2'b10}};
   assign seed_pattern = DATA_WIDTH'(START_WORD) ^ ALT_BITS;
   assign step_pattern = DATA_WIDTH'(addr_next) ^ ALT_BITS;
`endif

   // NOTE: all state and outputs are assigned with <= so every output is a clean flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         addr             <= '0;
         pattern          <= '0;
         word_cnt         <= '0;
         wait_cnt         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         error_count      <= '0;
         first_error_addr <= '0;
         m_axi_awaddr     <= '0;
         m_axi_awvalid    <= 1'b0;
         m_axi_wdata      <= '0;
         m_axi_wvalid     <= 1'b0;
         m_axi_araddr     <= '0;
         m_axi_arvalid    <= 1'b0;
         m_axi_rready     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state            <= WRITE;
                  addr             <= START_WORD;
                  pattern          <= seed_pattern;
                  word_cnt         <= '0;
                  error_count      <= '0;
                  first_error_addr <= '0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  m_axi_awaddr     <= START_WORD;
                  m_axi_wdata      <= seed_pattern;
                  m_axi_awvalid    <= 1'b1;
                  m_axi_wvalid     <= 1'b1;
               end
            end
            WRITE: begin
               // Address and data are offered together and only accepted as a pair.
               if (m_axi_awready && m_axi_wready) begin
                  if (last_word) begin
                     state         <= READ_REQ;
                     addr          <= START_WORD;
                     pattern       <= seed_pattern;
                     word_cnt      <= '0;
                     m_axi_awvalid <= 1'b0;
                     m_axi_wvalid  <= 1'b0;
                     m_axi_araddr  <= START_WORD;
                     m_axi_arvalid <= 1'b1;
                     m_axi_rready  <= 1'b1;
                  end else begin
                     addr         <= addr_next;
                     pattern      <= step_pattern;
                     word_cnt     <= word_cnt + 1'b1;
                     m_axi_awaddr <= addr_next;
                     m_axi_wdata  <= step_pattern;
                  end
               end
            end
            READ_REQ: begin
               if (m_axi_arready) begin
                  state         <= READ_WAIT;
                  m_axi_arvalid <= 1'b0;
                  wait_cnt      <= '0;
               end
            end
            READ_WAIT: begin
               // A missing response is scored like a mismatch and the sweep moves on.
               if (read_event) begin
                  if (read_error) begin
                     error_count <= err_cnt_inc;
                     if (error_count == '0) first_error_addr <= addr;
                  end
                  if (last_word) begin
                     state        <= DONE;
                     busy         <= 1'b0;
                     done         <= 1'b1;
                     pass         <= (error_count == '0) && !read_error;
                     m_axi_rready <= 1'b0;
                  end else begin
                     state         <= READ_REQ;
                     addr          <= addr_next;
                     pattern       <= step_pattern;
                     word_cnt      <= word_cnt + 1'b1;
                     m_axi_araddr  <= addr_next;
                     m_axi_arvalid <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_mem_tester.sv
// Directed bench for sdram_mem_tester: ideal one-read-outstanding memory model with
// stuck-bit, dropped-response and write-backpressure injection.
`timescale 1ns/1ps
module tb_sdram_mem_tester;

   localparam int AW  = 25;
   localparam int DW  = 16;
   localparam int EW  = 16;
   localparam int WC  = 4;
   localparam int SA  = 'h10;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, pass;
   logic [EW-1:0] error_count;
   logic [AW-1:0] first_error_addr;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic          m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

   always #5 clk = ~clk;

   sdram_mem_tester #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(SA), .WORD_COUNT(WC),
      .ERR_CNT_WIDTH(EW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .busy(busy), .done(done), .pass(pass),
      .error_count(error_count), .first_error_addr(first_error_addr),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Memory model state; logs only grow, tests remember their starting index.
   logic [DW-1:0] mem [0:63];
   logic [AW-1:0] wr_addr_log [$];
   logic [DW-1:0] wr_data_log [$];
   logic [AW-1:0] ar_addr_log [$];
   int            model_cyc = 0;
   int            bp_from = 0;
   int            bp_to = 0;
   bit            stuck_en = 1'b0;
   logic [AW-1:0] stuck_addr = '0;
   logic          stuck_val = 1'b0;
   bit            drop_en = 1'b0;
   logic [AW-1:0] drop_addr = '0;

   function automatic logic [DW-1:0] exp_data(input int i);
`ifdef SDRAM_MEM_TESTER_LFSR_EN
      case (i)
         0: return 16'hACE1;
         1: return 16'h5670;
         2: return 16'hAB38;
         default: return 16'h559C;
      endcase
`else
      case (i)
         0: return 16'hAABA;
         1: return 16'hAABB;
         2: return 16'hAAB8;
         default: return 16'hAAB9;
      endcase
`endif
   endfunction

   // Handshakes are sampled mid-cycle; responses are driven just after the clock edge.
   initial begin : mem_model
      logic          wr_fire, ar_fire;
      logic [AW-1:0] w_a, r_a;
      logic [DW-1:0] w_d;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      m_axi_awready = 1'b1;
      m_axi_wready  = 1'b1;
      m_axi_arready = 1'b1;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = '0;
      forever begin
         @(negedge clk);
         wr_fire = m_axi_awvalid && m_axi_awready && m_axi_wvalid && m_axi_wready;
         ar_fire = m_axi_arvalid && m_axi_arready;
         w_a = m_axi_awaddr;
         w_d = m_axi_wdata;
         r_a = m_axi_araddr;
         @(posedge clk);
         #1;
         model_cyc++;
         if (wr_fire) begin
            mem[w_a[5:0]] = w_d;
            wr_addr_log.push_back(w_a);
            wr_data_log.push_back(w_d);
         end
         if (ar_fire) ar_addr_log.push_back(r_a);
         m_axi_rvalid = ar_fire && !(drop_en && r_a == drop_addr);
         m_axi_rdata  = mem[r_a[5:0]];
         if (stuck_en && r_a == stuck_addr) m_axi_rdata[0] = stuck_val;
         m_axi_wready = !(model_cyc >= bp_from && model_cyc < bp_to);
      end
   end

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 1000) begin
         @(negedge clk);
         cycles++;
      end
      total_cnt++;
      if (done !== 1'b1) $display("FAIL done_reached: done=%b after %0d cycles, required 1", done, cycles);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({busy, done, pass, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready} !== 7'b0)
         $display("FAIL reset_ctrl: got %b, required 0000000",
                  {busy, done, pass, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready});
      else pass_cnt++;
      total_cnt++;
      if (error_count !== '0 || first_error_addr !== '0)
         $display("FAIL reset_err: count=%h addr=%h, required 0/0", error_count, first_error_addr);
      else pass_cnt++;
      total_cnt++;
      if (m_axi_awaddr !== '0 || m_axi_araddr !== '0 || m_axi_wdata !== '0)
         $display("FAIL reset_bus: aw=%h ar=%h wd=%h, required 0", m_axi_awaddr, m_axi_araddr, m_axi_wdata);
      else pass_cnt++;
      reset = 1'b0;
   endtask

   task automatic test_basic;
      int wb, ab, cyc;
      wb = wr_addr_log.size();
      ab = ar_addr_log.size();
      pulse_start();
      total_cnt++;
      if ({busy, m_axi_awvalid, m_axi_wvalid, done} !== 4'b1110)
         $display("FAIL basic_issue: busy/awv/wv/done=%b, required 1110", {busy, m_axi_awvalid, m_axi_wvalid, done});
      else pass_cnt++;
      total_cnt++;
      if (m_axi_awaddr !== AW'(SA) || m_axi_wdata !== exp_data(0))
         $display("FAIL basic_first_write: addr=%h data=%h, required %h/%h", m_axi_awaddr, m_axi_wdata, SA, exp_data(0));
      else pass_cnt++;
      wait_done(cyc);
      total_cnt++;
      if (cyc != 12) $display("FAIL basic_latency: %0d cycles, required 12", cyc);
      else pass_cnt++;
      total_cnt++;
      if (wr_addr_log.size() - wb != WC || ar_addr_log.size() - ab != WC)
         $display("FAIL basic_counts: writes=%0d reads=%0d, required 4/4", wr_addr_log.size() - wb, ar_addr_log.size() - ab);
      else pass_cnt++;
      for (int i = 0; i < WC; i++) begin
         total_cnt++;
         if (wr_addr_log[wb+i] !== AW'(SA + i) || wr_data_log[wb+i] !== exp_data(i) || ar_addr_log[ab+i] !== AW'(SA + i))
            $display("FAIL basic_word%0d: waddr=%h wdata=%h raddr=%h, required %h/%h/%h", i,
                     wr_addr_log[wb+i], wr_data_log[wb+i], ar_addr_log[ab+i], SA + i, exp_data(i), SA + i);
         else pass_cnt++;
      end
      total_cnt++;
      if ({done, pass, busy} !== 3'b110 || error_count !== '0)
         $display("FAIL basic_result: done/pass/busy=%b errors=%0d, required 110/0", {done, pass, busy}, error_count);
      else pass_cnt++;
   endtask

   task automatic test_start_while_busy;
      int wb, cyc;
      wb = wr_addr_log.size();
      pulse_start();
      total_cnt++;
      if ({done, busy} !== 2'b01) $display("FAIL restart_from_done: done/busy=%b, required 01", {done, busy});
      else pass_cnt++;
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      total_cnt++;
      if (cyc != 10 || wr_addr_log.size() - wb != WC)
         $display("FAIL busy_start_ignored: %0d cycles %0d writes, required 10/4", cyc, wr_addr_log.size() - wb);
      else pass_cnt++;
   endtask

   task automatic test_backpressure;
      int wb, cyc;
      wb = wr_addr_log.size();
      bp_from = model_cyc + 1;
      bp_to   = model_cyc + 4;
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         total_cnt++;
         if (!(m_axi_awvalid && m_axi_wvalid) || m_axi_awaddr !== AW'(SA) || m_axi_wdata !== exp_data(0) ||
             wr_addr_log.size() != wb)
            $display("FAIL bp_hold%0d: v=%b addr=%h data=%h writes=%0d, required 1/%h/%h/0", k,
                     m_axi_awvalid && m_axi_wvalid, m_axi_awaddr, m_axi_wdata, SA, exp_data(0), wr_addr_log.size() - wb);
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if (wr_addr_log.size() != wb) $display("FAIL bp_no_early: writes=%0d, required 0", wr_addr_log.size() - wb);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (wr_addr_log.size() != wb + 1 || m_axi_awaddr !== AW'(SA + 1) || m_axi_wdata !== exp_data(1))
         $display("FAIL bp_transfer: writes=%0d addr=%h data=%h, required 1/%h/%h",
                  wr_addr_log.size() - wb, m_axi_awaddr, m_axi_wdata, SA + 1, exp_data(1));
      else pass_cnt++;
      wait_done(cyc);
      total_cnt++;
      if (pass !== 1'b1 || wr_data_log[wb] !== exp_data(0))
         $display("FAIL bp_result: pass=%b first=%h, required 1/%h", pass, wr_data_log[wb], exp_data(0));
      else pass_cnt++;
   endtask

   task automatic test_stuck;
      int cyc;
      logic [DW-1:0] d;
      d = exp_data(2);
      stuck_en   = 1'b1;
      stuck_addr = AW'(SA + 2);
      stuck_val  = ~d[0];
      pulse_start();
      wait_done(cyc);
      stuck_en = 1'b0;
      total_cnt++;
      if (error_count !== EW'(1) || first_error_addr !== AW'(SA + 2) || pass !== 1'b0)
         $display("FAIL stuck_bit: errors=%0d addr=%h pass=%b, required 1/%h/0", error_count, first_error_addr, pass, SA + 2);
      else pass_cnt++;
   endtask

   task automatic test_timeout;
      int ab, cyc;
      ab = ar_addr_log.size();
      drop_en   = 1'b1;
      drop_addr = AW'(SA + 1);
      pulse_start();
      repeat (14) @(negedge clk);
      total_cnt++;
      if (error_count !== '0 || m_axi_arvalid !== 1'b0)
         $display("FAIL timeout_early: errors=%0d arvalid=%b, required 0/0", error_count, m_axi_arvalid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (error_count !== EW'(1) || first_error_addr !== AW'(SA + 1) || m_axi_arvalid !== 1'b1 || m_axi_araddr !== AW'(SA + 2))
         $display("FAIL timeout_count: errors=%0d addr=%h arv=%b araddr=%h, required 1/%h/1/%h",
                  error_count, first_error_addr, m_axi_arvalid, m_axi_araddr, SA + 1, SA + 2);
      else pass_cnt++;
      wait_done(cyc);
      drop_en = 1'b0;
      total_cnt++;
      if (cyc != 4 || ar_addr_log.size() - ab != WC || pass !== 1'b0)
         $display("FAIL timeout_finish: %0d cycles %0d reads pass=%b, required 4/4/0", cyc, ar_addr_log.size() - ab, pass);
      else pass_cnt++;
   endtask

   task automatic test_two_errors;
      int cyc;
      logic [DW-1:0] d;
      d = exp_data(1);
      stuck_en   = 1'b1;
      stuck_addr = AW'(SA + 1);
      stuck_val  = ~d[0];
      drop_en    = 1'b1;
      drop_addr  = AW'(SA + 3);
      pulse_start();
      wait_done(cyc);
      stuck_en = 1'b0;
      drop_en  = 1'b0;
      total_cnt++;
      if (cyc != 19 || error_count !== EW'(2) || first_error_addr !== AW'(SA + 1))
         $display("FAIL two_errors: %0d cycles errors=%0d addr=%h, required 19/2/%h", cyc, error_count, first_error_addr, SA + 1);
      else pass_cnt++;
   endtask

   task automatic test_reset_midrun;
      int ab, cyc;
      logic [DW-1:0] d;
      d = exp_data(0);
      stuck_en   = 1'b1;
      stuck_addr = AW'(SA);
      stuck_val  = ~d[0];
      pulse_start();
      repeat (6) @(negedge clk);
      total_cnt++;
      if (error_count !== EW'(1) || first_error_addr !== AW'(SA) || {m_axi_arvalid, m_axi_rready} !== 2'b11)
         $display("FAIL midrun_pre: errors=%0d addr=%h arv/rr=%b, required 1/%h/11",
                  error_count, first_error_addr, {m_axi_arvalid, m_axi_rready}, SA);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({m_axi_arvalid, m_axi_rready} !== 2'b01)
         $display("FAIL midrun_wait: arv/rr=%b, required 01", {m_axi_arvalid, m_axi_rready});
      else pass_cnt++;
      reset = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      stuck_en = 1'b0;
      total_cnt++;
      if ({busy, done, pass, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready} !== 7'b0 ||
          error_count !== '0 || first_error_addr !== '0)
         $display("FAIL midrun_abort: ctrl=%b errors=%0d addr=%h, required 0/0/0",
                  {busy, done, pass, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready}, error_count, first_error_addr);
      else pass_cnt++;
      ab = ar_addr_log.size();
      repeat (3) @(negedge clk);
      total_cnt++;
      if (ar_addr_log.size() != ab || m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0)
         $display("FAIL midrun_quiet: new reads=%0d awv=%b arv=%b, required 0/0/0",
                  ar_addr_log.size() - ab, m_axi_awvalid, m_axi_arvalid);
      else pass_cnt++;
      pulse_start();
      wait_done(cyc);
      total_cnt++;
      if (cyc != 12 || pass !== 1'b1 || error_count !== '0)
         $display("FAIL midrun_rerun: %0d cycles pass=%b errors=%0d, required 12/1/0", cyc, pass, error_count);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_start_while_busy();
      test_backpressure();
      test_stuck();
      test_timeout();
      test_two_errors();
      test_reset_midrun();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
